// File: rtl/sum_ascii_tx.sv
// Formats one signed sum at a time as ASCII decimal text: optional '-', digits without
// leading zeros, then a terminator byte, over valid/ready handshakes on both sides.
module sum_ascii_tx #(
  parameter int unsigned W    = 5,
  parameter logic [7:0]  TERM = 8'h0A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         busy
);

  typedef enum logic [2:0] {StIdle, StSign, StHund, StTens, StUnits, StTerm} state_e;

  state_e      state_q, state_d;
  logic        neg_q, neg_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;
  logic [7:0]  byte_d;

  logic [W:0]  in_ext;
  logic [W:0]  in_mag;
  int unsigned mag_int;
  logic [3:0]  in_hund, in_tens, in_units;

  // One extra magnitude bit so the most negative input is represented exactly.
  always_comb begin
    in_ext   = {in_data[W-1], in_data};
    in_mag   = in_data[W-1] ? (~in_ext + 1'b1) : in_ext;
    mag_int  = 32'(in_mag);
    in_hund  = 4'(mag_int / 100);
    in_tens  = 4'((mag_int / 10) % 10);
    in_units = 4'(mag_int % 10);
  end

  function automatic state_e lead_state(input logic [3:0] h, input logic [3:0] t);
    if (h != 4'd0)      return StHund;
    else if (t != 4'd0) return StTens;
    else                return StUnits;
  endfunction

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    units_d = units_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          neg_d   = in_data[W-1];
          hund_d  = in_hund;
          tens_d  = in_tens;
          units_d = in_units;
          state_d = in_data[W-1] ? StSign : lead_state(in_hund, in_tens);
        end
      end
      StSign:  if (out_ready) state_d = lead_state(hund_q, tens_q);
      StHund:  if (out_ready) state_d = StTens;
      StTens:  if (out_ready) state_d = StUnits;
      StUnits: if (out_ready) state_d = StTerm;
      StTerm:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte presented in the state about to be entered; held while idle.
  always_comb begin
    byte_d = out_data;
    case (state_d)
      StSign:  byte_d = 8'h2D;
      StHund:  byte_d = 8'h30 + {4'h0, hund_d};
      StTens:  byte_d = 8'h30 + {4'h0, tens_d};
      StUnits: byte_d = 8'h30 + {4'h0, units_d};
      StTerm:  byte_d = TERM;
      default: byte_d = out_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      neg_q     <= 1'b0;
      hund_q    <= 4'd0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      out_valid <= (state_d != StIdle);
      out_data  <= byte_d;
    end
  end

  assign in_ready = (state_q == StIdle) && !rst;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_sum_ascii_tx.sv
// Self-checking bench: drives signed values into W=5 and W=8 instances and compares the
// emitted byte streams against decimal text produced by $sformatf.
module tb_sum_ascii_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_val = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready5, out_valid5, busy5;
  logic [7:0] out_data5;
  logic       in_ready8, out_valid8, busy8;
  logic [7:0] out_data8;

  logic       in_ready_m, out_valid_m, busy_m;
  logic [7:0] out_data_m;

  int checks = 0;
  int errors = 0;
  int term_count = 0;

  always #5 clk = ~clk;

  sum_ascii_tx #(.W(5), .TERM(8'h0A)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready5),
    .in_data(in_val[4:0]), .out_valid(out_valid5), .out_ready(out_ready),
    .out_data(out_data5), .busy(busy5)
  );

  sum_ascii_tx #(.W(8), .TERM(8'h0A)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready8),
    .in_data(in_val), .out_valid(out_valid8), .out_ready(out_ready),
    .out_data(out_data8), .busy(busy8)
  );

  assign in_ready_m  = sel ? in_ready8  : in_ready5;
  assign out_valid_m = sel ? out_valid8 : out_valid5;
  assign out_data_m  = sel ? out_data8  : out_data5;
  assign busy_m      = sel ? busy8      : busy5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the terminator handshake.
  task automatic send_value(input int v, input bit tied);
    byte   exp_q[$];
    string s;
    int    idx, cycles, busy_cnt, wait_cnt;
    bit    r, prev_stall;
    logic [7:0] prev_data;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);

    in_valid = 1'b1;
    in_val   = 8'(v);
    wait_cnt = 0;
    while (!in_ready_m && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("accept_wait", 32'(in_ready_m), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("first_byte_latency", 32'(out_valid_m), 32'd1);

    idx = 0; cycles = 0; busy_cnt = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (idx < exp_q.size() && cycles < 200) begin
      r = tied ? 1'b1 : 1'($urandom_range(0, 1));
      out_ready = r;
      check("frame_valid", 32'(out_valid_m), 32'd1);
      check("in_ready_low", 32'(in_ready_m), 32'd0);
      check($sformatf("byte%0d_of_%0d", idx, v), 32'(out_data_m), 32'(exp_q[idx]));
      if (prev_stall) check("stall_hold", 32'(out_data_m), 32'(prev_data));
      if (busy_m) busy_cnt++;
      prev_stall = out_valid_m && !r;
      prev_data  = out_data_m;
      if (out_valid_m && r) begin
        if (out_data_m == 8'h0A) term_count++;
        idx++;
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b0;
    check("frame_complete", 32'(idx), 32'(exp_q.size()));
    check("idle_valid", 32'(out_valid_m), 32'd0);
    check("idle_busy", 32'(busy_m), 32'd0);
    check("idle_ready", 32'(in_ready_m), 32'd1);
    if (tied) check("busy_cycles", 32'(busy_cnt), 32'(exp_q.size()));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready_m), 32'd0);
    check("rst_out_valid", 32'(out_valid_m), 32'd0);
    check("rst_out_data", 32'(out_data_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready_m), 32'd1);
    check("post_rst_valid", 32'(out_valid_m), 32'd0);

    // Single positive value, then back-to-back mixed signs
    send_value(5, 1'b1);
    send_value(-16, 1'b1);
    send_value(0, 1'b1);
    send_value(15, 1'b1);
    send_value(-1, 1'b1);

    // Backpressure: random out_ready
    send_value(-7, 1'b0);
    for (int i = 0; i < 6; i++) send_value($urandom_range(0, 31) - 16, 1'b0);

    // Wide instance: three-digit values with inner zeros
    sel = 1'b1;
    @(negedge clk);
    send_value(-128, 1'b1);
    send_value(100, 1'b1);
    send_value(127, 1'b1);
    send_value(-105, 1'b0);
    for (int i = 0; i < 6; i++) send_value($urandom_range(0, 255) - 128, 1'b0);
    sel = 1'b0;
    @(negedge clk);

    // Reset after the '-' handshake drops the rest of the frame
    in_valid = 1'b1;
    in_val   = 8'(-12);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_sign", 32'(out_data_m), 32'h2D);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rst_mid_digit", 32'(out_data_m), 32'h31);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid_m), 32'd0);
    check("rst_mid_busy", 32'(busy_m), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(in_ready_m), 32'd1);
    check("rst_mid_valid2", 32'(out_valid_m), 32'd0);
    send_value(3, 1'b1);

    // Exhaustive W=5 sweep, counting terminators
    term_count = 0;
    for (int v = -16; v <= 15; v++) send_value(v, 1'b1);
    check("term_count", 32'(term_count), 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_ascii_tx.md
# sum_ascii_tx

Output-side formatter for the signed adder datapath. It accepts signed sums one at a time over a valid/ready handshake and emits each as a stream of ASCII bytes: optional `-`, decimal digits with leading zeros suppressed, then a terminator byte. It is the hardware writer for the sum result stream, used to feed a byte sink (UART/log capture) with the same text the simulation flow produces as one decimal value per line. Single clock domain, no internal FIFO; one value in flight at a time.

## Interface
- `W`, 5, width of signed input sum; legal range 2..8 (max 3 magnitude digits).
- `TERM`, 8'h0A, terminator byte appended after every value.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a value to format.
- `in_ready`  out  1  block can accept a value this cycle.
- `in_data`  in  W  signed two's-complement sum.
- `out_valid`  out  1  `out_data` holds a byte.
- `out_ready`  in  1  sink takes the byte this cycle.
- `out_data`  out  8  ASCII byte.
- `busy`  out  1  a value is latched and not yet fully emitted.

## Operation
- FSM states: IDLE, SIGN, HUND, TENS, UNITS, TERM.
- IDLE: `in_ready`=1 (forced 0 while `rst`=1). On `in_valid & in_ready`, latch `in_data`; compute sign, magnitude |x| (W+1-bit unsigned, so -2^(W-1) is exact), and hundreds/tens/units digits.
- Next state after accept: SIGN if negative; else first non-zero leading digit state; UNITS if magnitude < 10 (includes 0).
- SIGN emits 8'h2D (`-`). HUND/TENS/UNITS emit 8'h30 + digit. TERM emits `TERM`.
- Leading-zero suppression: HUND skipped if hundreds=0; TENS skipped if hundreds=0 and tens=0. Inner zeros are emitted (e.g. 100 → `1`,`0`,`0`). Value 0 emits `0`.
- Each state holds `out_valid`=1 with stable `out_data` until `out_ready`=1; the state advances on the handshake edge. After the TERM handshake, return to IDLE.
- `busy` = (state != IDLE).
- `in_valid` while not in IDLE is ignored; the source holds it (standard valid/ready).

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=8'h00, `busy`=0, latched value 0; `in_ready`=0 during reset, 1 in the first cycle after `rst` is deasserted.
- Accept at edge k → `out_valid`=1 with first byte from cycle k+1 (1-cycle latency).
- With `out_ready` tied high: one byte per cycle; a value of n bytes (including terminator) occupies n cycles in output states plus 1 IDLE/accept cycle. Minimum period between accepts = n+1 cycles.
- `in_ready` is 0 in the cycle of the TERM handshake; the next value is accepted no earlier than the following cycle.
- `out_valid` is never deasserted without a handshake, except by reset.
- Reset mid-value: the remaining bytes are dropped, `out_valid`=0 in the cycle after the reset edge, the FSM returns to IDLE, and no partial terminator is emitted.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Test plan
- W=5, reset then push 5 with `out_ready`=1 → bytes 8'h35, 8'h0A on consecutive cycles; first byte in the cycle after accept; `busy` high for 2 cycles.
- W=5, push -16, 0, 15, -1 back-to-back → streams `-16\n`, `0\n`, `15\n`, `-1\n` (2D 31 36 0A / 30 0A / 31 35 0A / 2D 31 0A); `in_ready` low during each frame.
- W=5, push -7 with `out_ready` toggling pseudo-randomly → `out_data` and `out_valid` stable while `out_ready`=0; the sequence 2D 37 0A is unchanged.
- W=8, push -128, 100, 127 → `-128\n`, `100\n`, `127\n`; the inner zeros of 100 are present.
- W=5, push -12, then assert `rst` after the `-` handshake → no further bytes; `out_valid`=0, `busy`=0, and `in_ready`=1 after release; the next push of 3 emits 33 0A.
- W=5, all 32 values -16..15 with `out_ready`=1, compared against a reference decimal formatter → zero mismatches, and exactly 32 terminators.
